bcd_clock_counter: RTL and testbench
====================================

Name: bcd_clock_counter

Overview:
- Next-generation BCD time-of-day counter for the alarm clock datapath.
- Holds HH:MM:SS in packed BCD and advances on a one-second (or one-minute) tick.
- Adds: optional seconds field, 12/24-hour display mode with PM flag, validated loads, independent hour/minute set buttons, day-wrap pulse.
- Feeds the display mux and the alarm comparator.

Parameters:
- SEC_EN, 1: 1 = seconds field counts and tick is a 1 s pulse; 0 = seconds held at 00 and tick is a 1 min pulse.
- RESET_TIME, 24'h000000: 24-hour BCD HHMMSS loaded on reset. Must be a valid time; an elaboration check fails otherwise.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low; clock clk
- tick  input  1  single-cycle advance strobe (1 s if SEC_EN=1, 1 min if SEC_EN=0)
- load_time  input  1  load set_data/set_pm this cycle
- set_data  input  24  BCD HHMMSS, interpreted in the current display mode
- set_pm  input  1  PM flag for loads in 12 h mode; ignored in 24 h mode
- inc_min  input  1  set-button strobe: minutes +1
- inc_hr  input  1  set-button strobe: hours +1
- mode_12h  input  1  display/load mode: 1 = 12 h, 0 = 24 h
- time_data  output  24  displayed BCD HHMMSS
- pm  output  1  1 when internal hour is 12–23, in either mode
- day_wrap  output  1  one-cycle pulse when tick rolls 23:59:59 to 00:00:00
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- State is stored internally as 24 h BCD: hr 00–23, min 00–59, sec 00–59. All digits are always valid BCD.
- Reset (async, low): state = RESET_TIME; day_wrap = 0; load_err = 0.
- Update priority per clock edge: load_time > (inc_hr / inc_min) > tick. A tick that loses priority is dropped, not deferred.
- Load:
  - Validation: all six nibbles ≤ 9; min ≤ 59; sec ≤ 59.
  - Hours in 24 h mode: 00–23.
  - Hours in 12 h mode: 01–12.
  - If SEC_EN=0, the seconds field must be 00.
  - Valid load: state updated next edge.
  - 12 h to internal conversion: 12 with !set_pm → 00; 12 with set_pm → 12; h with set_pm → h+12; h with !set_pm → h.
  - Invalid load: state unchanged; load_err = 1 for one cycle.
- inc_min: min = (min+1) mod 60; no carry into hours; sec cleared to 00.
- inc_hr: hr = (hr+1) mod 24; no carry, no day_wrap.
- inc_min and inc_hr together: both apply in the same edge.
- Tick (SEC_EN=1): sec+1 with BCD digit carry.
  - x9 → (x+1)0.
  - 59 → 00 with carry into min; min 59 → 00 with carry into hr.
  - hr 09 → 10, 19 → 20, 23 → 00.
  - 23:59:59 → 00:00:00 asserts day_wrap = 1 for exactly the following cycle.
- Tick (SEC_EN=0): same carry chain starting at minutes. 23:59 → 00:00 asserts day_wrap. Seconds stay 00.
- Tick on a cycle with load_time, inc_min or inc_hr: ignored; day_wrap stays 0.
- Output mapping:
  - time_data[15:0] = internal min/sec, registered.
  - time_data[23:16]: 24 h mode shows the internal hour. 12 h mode shows 00→12, 01–11 as-is, 12→12, 13–23 → 01–11.
  - The hour mapping is combinational from the registered state and mode_12h. Toggling mode_12h changes the display in the same cycle and never modifies state.
- pm is combinational from the internal hour and is valid in both modes.
- Reset mid-operation: immediate return to RESET_TIME; pending pulses cleared.

Test Plan:
- Reset with RESET_TIME=24'h235958: one tick → 23:59:59, day_wrap=0; next tick → 00:00:00 with day_wrap=1 for one cycle, then 0.
- Carry chain, 24 h: load 09:59:59 then tick → 10:00:00; load 19:59:59 then tick → 20:00:00; load 12:34:09 then tick → 12:34:10.
- 12 h mode: load 12:00:00 with set_pm=0 → internal 00, display 12, pm=0. Load 01:30:00 with set_pm=1 → internal 13, display 01, pm=1. Set mode_12h=0 → display 13:30:00, state unchanged.
- Invalid loads: 24:00:00, 12:60:00, 0A:00:00, and 00:xx:xx in 12 h mode → load_err pulse, time_data unchanged. 23:59:59 in 24 h mode → accepted.
- Set buttons: at 10:59:30, inc_min → 10:00:00. inc_hr at 23:xx → 00:xx with no day_wrap. inc_hr+inc_min together at 05:07:00 → 06:08:00. Tick in the same cycle as inc is dropped.
- SEC_EN=0: tick advances 23:58 → 23:59 → 00:00 with day_wrap; seconds read 00 throughout. Load with sec=05 → load_err.

Source files
------------

// File: rtl/bcd_clock_counter.sv
// BCD time-of-day counter: 24 h internal HH:MM:SS, 12/24 h display, validated loads,
// set buttons and a day-wrap pulse for the display mux and alarm comparator.
module bcd_clock_counter #(
  parameter bit          SEC_EN     = 1'b1,
  parameter logic [23:0] RESET_TIME = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load_time,
  input  logic [23:0] set_data,
  input  logic        set_pm,
  input  logic        inc_min,
  input  logic        inc_hr,
  input  logic        mode_12h,
  output logic [23:0] time_data,
  output logic        pm,
  output logic        day_wrap,
  output logic        load_err
);

  function automatic logic digits_ok(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // With every digit valid, packed BCD compares numerically.
  function automatic logic time_ok(input logic [23:0] t);
    return digits_ok(t) && (t[23:16] <= 8'h23) && (t[15:8] <= 8'h59) && (t[7:0] <= 8'h59);
  endfunction

  function automatic logic [4:0] bcd2bin(input logic [7:0] b);
    return ({1'b0, b[7:4]} * 5'd10) + {1'b0, b[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [4:0] v);
    logic [3:0] t;
    logic [4:0] r;
    if (v >= 5'd20) begin
      t = 4'd2; r = v - 5'd20;
    end else if (v >= 5'd10) begin
      t = 4'd1; r = v - 5'd10;
    end else begin
      t = 4'd0; r = v;
    end
    return {t, r[3:0]};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  if (!time_ok(RESET_TIME)) begin : g_bad_reset_time
    $error("bcd_clock_counter: RESET_TIME is not a valid 24 h BCD time");
  end

  logic [7:0] hr_q, min_q, sec_q;
  logic [7:0] hr_d, min_d, sec_d;
  logic       day_wrap_q, load_err_q;
  logic       day_wrap_d, load_err_d;

  logic       ld_ok;
  logic [7:0] ld_hr;
  logic [7:0] tk_hr, tk_min, tk_sec;
  logic       tk_wrap;
  logic [4:0] hr_bin;
  logic [7:0] disp_hr;

  always_comb begin
    ld_ok = digits_ok(set_data) && (set_data[15:8] <= 8'h59) && (set_data[7:0] <= 8'h59)
            && (SEC_EN || (set_data[7:0] == 8'h00))
            && (mode_12h ? ((set_data[23:16] >= 8'h01) && (set_data[23:16] <= 8'h12))
                         : (set_data[23:16] <= 8'h23));
    ld_hr = set_data[23:16];
    if (mode_12h) begin
      if (set_data[23:16] == 8'h12) ld_hr = set_pm ? 8'h12 : 8'h00;
      else if (set_pm)              ld_hr = bin2bcd(bcd2bin(set_data[23:16]) + 5'd12);
    end
  end

  // Carry chain starts at seconds or minutes depending on the tick rate.
  always_comb begin
    if (SEC_EN) begin
      tk_sec  = bcd_inc(sec_q, 8'h59);
      tk_min  = (sec_q == 8'h59) ? bcd_inc(min_q, 8'h59) : min_q;
      tk_hr   = (sec_q == 8'h59 && min_q == 8'h59) ? bcd_inc(hr_q, 8'h23) : hr_q;
      tk_wrap = (sec_q == 8'h59) && (min_q == 8'h59) && (hr_q == 8'h23);
    end else begin
      tk_sec  = 8'h00;
      tk_min  = bcd_inc(min_q, 8'h59);
      tk_hr   = (min_q == 8'h59) ? bcd_inc(hr_q, 8'h23) : hr_q;
      tk_wrap = (min_q == 8'h59) && (hr_q == 8'h23);
    end
  end

  // Priority: load, then set buttons, then tick; a losing tick is dropped.
  always_comb begin
    hr_d       = hr_q;
    min_d      = min_q;
    sec_d      = sec_q;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;
    if (load_time) begin
      if (ld_ok) begin
        hr_d  = ld_hr;
        min_d = set_data[15:8];
        sec_d = set_data[7:0];
      end else begin
        load_err_d = 1'b1;
      end
    end else if (inc_hr || inc_min) begin
      if (inc_hr) hr_d = bcd_inc(hr_q, 8'h23);
      if (inc_min) begin
        min_d = bcd_inc(min_q, 8'h59);
        sec_d = 8'h00;
      end
    end else if (tick) begin
      hr_d       = tk_hr;
      min_d      = tk_min;
      sec_d      = tk_sec;
      day_wrap_d = tk_wrap;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hr_q       <= RESET_TIME[23:16];
      min_q      <= RESET_TIME[15:8];
      sec_q      <= SEC_EN ? RESET_TIME[7:0] : 8'h00;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    hr_bin  = bcd2bin(hr_q);
    disp_hr = hr_q;
    if (mode_12h) begin
      if (hr_q == 8'h00)       disp_hr = 8'h12;
      else if (hr_q > 8'h12)   disp_hr = bin2bcd(hr_bin - 5'd12);
    end
  end

  assign time_data = {disp_hr, min_q, sec_q};
  assign pm        = (hr_q >= 8'h12);
  assign day_wrap  = day_wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Scoreboard bench: two counters (1 s tick from 23:59:58, 1 min tick from 23:58), steps
// queued with their expected outputs and compared one cycle after being driven.
module tb_bcd_clock_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick0 = 0, ld0 = 0, spm0 = 0, im0 = 0, ih0 = 0, m120 = 0;
  logic [23:0] d0 = '0;
  logic [23:0] td0;
  logic        pm0, dw0, le0;
  logic        tick1 = 0, ld1 = 0;
  logic [23:0] d1 = '0;
  logic [23:0] td1;
  logic        pm1, dw1, le1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bcd_clock_counter #(.SEC_EN(1'b1), .RESET_TIME(24'h235958)) u0 (
    .clk(clk), .reset(rst_n), .tick(tick0), .load_time(ld0), .set_data(d0), .set_pm(spm0),
    .inc_min(im0), .inc_hr(ih0), .mode_12h(m120),
    .time_data(td0), .pm(pm0), .day_wrap(dw0), .load_err(le0));

  bcd_clock_counter #(.SEC_EN(1'b0), .RESET_TIME(24'h235800)) u1 (
    .clk(clk), .reset(rst_n), .tick(tick1), .load_time(ld1), .set_data(d1), .set_pm(1'b0),
    .inc_min(1'b0), .inc_hr(1'b0), .mode_12h(1'b0),
    .time_data(td1), .pm(pm1), .day_wrap(dw1), .load_err(le1));

  typedef struct {
    string       nm;
    bit          u1;
    logic        ld, spm, im, ih, tk, m12;
    logic [23:0] d;
    logic [23:0] et;
    logic        epm, edw, ele;
  } step_t;

  step_t q[$];
  step_t s;
  logic [26:0] obs;

  task automatic push(input string nm, input bit u1, input logic ld, input logic [23:0] d,
                      input logic spm, input logic im, input logic ih, input logic tk,
                      input logic m12, input logic [23:0] et, input logic epm,
                      input logic edw, input logic ele);
    step_t t;
    t.nm = nm; t.u1 = u1; t.ld = ld; t.d = d; t.spm = spm; t.im = im; t.ih = ih;
    t.tk = tk; t.m12 = m12; t.et = et; t.epm = epm; t.edw = edw; t.ele = ele;
    q.push_back(t);
  endtask

  task automatic drive(input step_t t);
    if (t.u1) begin
      tick1 = t.tk; ld1 = t.ld; d1 = t.d;
    end else begin
      tick0 = t.tk; ld0 = t.ld; d0 = t.d; spm0 = t.spm; im0 = t.im; ih0 = t.ih; m120 = t.m12;
    end
  endtask

  task automatic clear_strobes();
    tick0 = 0; ld0 = 0; im0 = 0; ih0 = 0; spm0 = 0; tick1 = 0; ld1 = 0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({td0, pm0, dw0, le0} !== {24'h235958, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_u0: got %h pm=%b dw=%b le=%b, want 235958 pm=1 dw=0 le=0", td0, pm0, dw0, le0);
    else n_pass++;
    n_chk++;
    if ({td1, pm1, dw1, le1} !== {24'h235800, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_u1: got %h pm=%b dw=%b le=%b, want 235800 pm=1 dw=0 le=0", td1, pm1, dw1, le1);
    else n_pass++;
  endtask

  task automatic test_day_wrap();
    push("tick_2359_59", 0, 0, 0, 0, 0, 0, 1, 0, 24'h235959, 1, 0, 0);
    push("tick_wrap",    0, 0, 0, 0, 0, 0, 1, 0, 24'h000000, 0, 1, 0);
    push("wrap_clear",   0, 0, 0, 0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td0, pm0, dw0, le0}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
  endtask

  task automatic test_carry();
    push("ld_095959",  0, 1, 24'h095959, 0, 0, 0, 0, 0, 24'h095959, 0, 0, 0);
    push("carry_09",   0, 0, 0,          0, 0, 0, 1, 0, 24'h100000, 0, 0, 0);
    push("ld_195959",  0, 1, 24'h195959, 0, 0, 0, 0, 0, 24'h195959, 1, 0, 0);
    push("carry_19",   0, 0, 0,          0, 0, 0, 1, 0, 24'h200000, 1, 0, 0);
    push("ld_123409",  0, 1, 24'h123409, 0, 0, 0, 0, 0, 24'h123409, 1, 0, 0);
    push("carry_x9",   0, 0, 0,          0, 0, 0, 1, 0, 24'h123410, 1, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td0, pm0, dw0, le0}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
  endtask

  task automatic test_12h();
    push("ld_12am",    0, 1, 24'h120000, 0, 0, 0, 0, 1, 24'h120000, 0, 0, 0);
    push("disp_00_24", 0, 0, 0,          0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
    push("ld_1pm",     0, 1, 24'h013000, 1, 0, 0, 0, 1, 24'h013000, 1, 0, 0);
    push("to_24h",     0, 0, 0,          0, 0, 0, 0, 0, 24'h133000, 1, 0, 0);
    push("back_12h",   0, 0, 0,          0, 0, 0, 0, 1, 24'h013000, 1, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td0, pm0, dw0, le0}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
  endtask

  task automatic test_invalid_load();
    push("bad_hr24",   0, 1, 24'h240000, 0, 0, 0, 0, 0, 24'h133000, 1, 0, 1);
    push("bad_min60",  0, 1, 24'h126000, 0, 0, 0, 0, 0, 24'h133000, 1, 0, 1);
    push("bad_nibA",   0, 1, 24'h0A0000, 0, 0, 0, 0, 0, 24'h133000, 1, 0, 1);
    push("bad_12h_00", 0, 1, 24'h001234, 0, 0, 0, 0, 1, 24'h013000, 1, 0, 1);
    push("err_clear",  0, 0, 0,          0, 0, 0, 0, 0, 24'h133000, 1, 0, 0);
    push("ld_235959",  0, 1, 24'h235959, 0, 0, 0, 0, 0, 24'h235959, 1, 0, 0);
    push("disp_23_12", 0, 0, 0,          0, 0, 0, 0, 1, 24'h115959, 1, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td0, pm0, dw0, le0}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
  endtask

  task automatic test_buttons();
    push("ld_105930",  0, 1, 24'h105930, 0, 0, 0, 0, 0, 24'h105930, 0, 0, 0);
    push("inc_min_59", 0, 0, 0,          0, 1, 0, 0, 0, 24'h100000, 0, 0, 0);
    push("ld_234512",  0, 1, 24'h234512, 0, 0, 0, 0, 0, 24'h234512, 1, 0, 0);
    push("inc_hr_23",  0, 0, 0,          0, 0, 1, 0, 0, 24'h004512, 0, 0, 0);
    push("disp_00_12", 0, 0, 0,          0, 0, 0, 0, 1, 24'h124512, 0, 0, 0);
    push("ld_050700",  0, 1, 24'h050700, 0, 0, 0, 0, 0, 24'h050700, 0, 0, 0);
    push("inc_both",   0, 0, 0,          0, 1, 1, 0, 0, 24'h060800, 0, 0, 0);
    push("ld_060815",  0, 1, 24'h060815, 0, 0, 0, 0, 0, 24'h060815, 0, 0, 0);
    push("inc_min_tk", 0, 0, 0,          0, 1, 0, 1, 0, 24'h060900, 0, 0, 0);
    push("ld_tk_drop", 0, 1, 24'h235959, 0, 0, 0, 1, 0, 24'h235959, 1, 0, 0);
    push("tk_wrap2",   0, 0, 0,          0, 0, 0, 1, 0, 24'h000000, 0, 1, 0);
    push("inc_hr_tk",  0, 0, 0,          0, 0, 1, 1, 0, 24'h010000, 0, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td0, pm0, dw0, le0}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
  endtask

  task automatic test_minute_tick();
    push("m_tick_2359", 1, 0, 0,          0, 0, 0, 1, 0, 24'h235900, 1, 0, 0);
    push("m_tick_wrap", 1, 0, 0,          0, 0, 0, 1, 0, 24'h000000, 0, 1, 0);
    push("m_wrap_clr",  1, 0, 0,          0, 0, 0, 0, 0, 24'h000000, 0, 0, 0);
    push("m_bad_sec",   1, 1, 24'h120005, 0, 0, 0, 0, 0, 24'h000000, 0, 0, 1);
    push("m_ld_1200",   1, 1, 24'h120000, 0, 0, 0, 0, 0, 24'h120000, 1, 0, 0);
    push("m_tick_1201", 1, 0, 0,          0, 0, 0, 1, 0, 24'h120100, 1, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td1, pm1, dw1, le1}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    push("mid_ld",   0, 1, 24'h235959, 0, 0, 0, 0, 0, 24'h235959, 1, 0, 0);
    push("mid_wrap", 0, 0, 0,          0, 0, 0, 1, 0, 24'h000000, 0, 1, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); drive(s); @(posedge clk); #1; clear_strobes();
      obs = {td0, pm0, dw0, le0}; n_chk++;
      if (obs !== {s.et, s.epm, s.edw, s.ele})
        $display("FAIL %s: got %h/%b%b%b want %h/%b%b%b", s.nm, obs[26:3], obs[2], obs[1], obs[0], s.et, s.epm, s.edw, s.ele);
      else n_pass++;
    end
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({td0, pm0, dw0, le0} !== {24'h235958, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_mid_u0: got %h pm=%b dw=%b le=%b, want 235958 pm=1 dw=0 le=0", td0, pm0, dw0, le0);
    else n_pass++;
    n_chk++;
    if (td1 !== 24'h235800)
      $display("FAIL reset_mid_u1: got %h, want 235800", td1);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_day_wrap();
    test_carry();
    test_12h();
    test_invalid_load();
    test_buttons();
    test_minute_tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
